// File: rtl/mem_wb_stage.sv
// MEM stage plus MEM/WB pipeline register: data-memory access over req/ack with timeout abort,
// branch/jump redirect, write-back staging. Optional build macro: MEM_MISALIGN_TRAP_EN.
module mem_wb_stage #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              I_Valid,
    input  logic [1:0]        I_WB,
    input  logic              I_M_Branch,
    input  logic              I_M_MemRead,
    input  logic              I_M_MemWrite,
    input  logic [DATA_W-1:0] I_ADD_Res,
    input  logic              I_ZF,
    input  logic [DATA_W-1:0] I_ALU_Res,
    input  logic [DATA_W-1:0] I_DatWri_Mem,
    input  logic [4:0]        I_Addr_Reg_Wri,
    input  logic              I_Jump,
    input  logic [DATA_W-1:0] I_Ins32_J,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic              O_Stall,
    output logic              O_PCSrc,
    output logic [DATA_W-1:0] O_PC_Target,
    output logic              O_Valid,
    output logic [1:0]        O_WB,
    output logic [DATA_W-1:0] O_ReadData,
    output logic [DATA_W-1:0] O_ALU_Res,
    output logic [4:0]        O_Addr_Reg_Wri,
    output logic              O_BusErr,
    output logic              O_FsmState
);
    // Memory handshake: dmem_req stays high from the first ACCESS cycle until the cycle in which
    // dmem_ack pulses (or the timeout fires); dmem_addr/dmem_wdata/dmem_we are stable throughout.
    typedef enum logic {S_IDLE = 1'b0, S_ACCESS = 1'b1} state_t;

    state_t              state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                we_q;
    logic [DATA_W-1:0]   addr_q, wdata_q;
    logic [1:0]          ent_wb_q;
    logic [DATA_W-1:0]   ent_alu_q;
    logic [4:0]          ent_dest_q;
    logic                valid_q, valid_d;
    logic [1:0]          wb_q, wb_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [DATA_W-1:0]   alu_q, alu_d;
    logic [4:0]          dest_q, dest_d;
    logic                buserr_q, buserr_d;
    logic                stall, lat_en, memop, trap;

    assign memop = I_Valid & (I_M_MemRead | I_M_MemWrite);
`ifdef MEM_MISALIGN_TRAP_EN
    assign trap = memop & (I_ALU_Res[1:0] != 2'b00);
`else
    assign trap = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stall    = 1'b0;
        lat_en   = 1'b0;
        valid_d  = valid_q;
        wb_d     = wb_q;
        rdata_d  = rdata_q;
        alu_d    = alu_q;
        dest_d   = dest_q;
        buserr_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = 8'd0;
                if (trap) begin
                    valid_d  = 1'b1;
                    wb_d     = 2'b00;
                    rdata_d  = '0;
                    alu_d    = I_ALU_Res;
                    dest_d   = I_Addr_Reg_Wri;
                    buserr_d = 1'b1;
                end else if (memop) begin
                    stall   = 1'b1;
                    lat_en  = 1'b1;
                    state_d = S_ACCESS;
                    valid_d = 1'b0;
                    wb_d    = 2'b00;
                end else begin
                    valid_d = I_Valid;
                    wb_d    = I_WB;
                    rdata_d = '0;
                    alu_d   = I_ALU_Res;
                    dest_d  = I_Addr_Reg_Wri;
                end
            end
            S_ACCESS: begin
                if (dmem_ack) begin
                    state_d = S_IDLE;
                    cnt_d   = 8'd0;
                    valid_d = 1'b1;
                    wb_d    = ent_wb_q;
                    rdata_d = we_q ? '0 : dmem_rdata;
                    alu_d   = ent_alu_q;
                    dest_d  = ent_dest_q;
                end else if (cnt_q == 8'(TIMEOUT)) begin
                    // Abort: retire the entry but suppress its write-back.
                    state_d  = S_IDLE;
                    cnt_d    = 8'd0;
                    valid_d  = 1'b1;
                    wb_d     = 2'b00;
                    rdata_d  = '0;
                    alu_d    = ent_alu_q;
                    dest_d   = ent_dest_q;
                    buserr_d = 1'b1;
                end else begin
                    stall   = 1'b1;
                    cnt_d   = cnt_q + 8'd1;
                    valid_d = 1'b0;
                    wb_d    = 2'b00;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= 8'd0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            ent_wb_q   <= 2'b00;
            ent_alu_q  <= '0;
            ent_dest_q <= 5'd0;
            valid_q    <= 1'b0;
            wb_q       <= 2'b00;
            rdata_q    <= '0;
            alu_q      <= '0;
            dest_q     <= 5'd0;
            buserr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            wb_q     <= wb_d;
            rdata_q  <= rdata_d;
            alu_q    <= alu_d;
            dest_q   <= dest_d;
            buserr_q <= buserr_d;
            if (lat_en) begin
                we_q       <= I_M_MemWrite;
                addr_q     <= {I_ALU_Res[DATA_W-1:2], 2'b00};
                wdata_q    <= I_DatWri_Mem;
                ent_wb_q   <= I_WB;
                ent_alu_q  <= I_ALU_Res;
                ent_dest_q <= I_Addr_Reg_Wri;
            end
        end
    end

    assign dmem_req       = (state_q == S_ACCESS);
    assign dmem_we        = we_q;
    assign dmem_addr      = addr_q;
    assign dmem_wdata     = wdata_q;
    assign O_Stall        = stall;
    assign O_PCSrc        = I_Valid & ~stall & ((I_M_Branch & I_ZF) | I_Jump);
    assign O_PC_Target    = I_Jump ? I_Ins32_J : I_ADD_Res;
    assign O_Valid        = valid_q;
    assign O_WB           = wb_q;
    assign O_ReadData     = rdata_q;
    assign O_ALU_Res      = alu_q;
    assign O_Addr_Reg_Wri = dest_q;
    assign O_BusErr       = buserr_q;
    assign O_FsmState     = (state_q == S_ACCESS);
endmodule
